// File: rtl/mmio_pkg.sv
// ----------------------------------------------------------------------------
// mmio_pkg
//   Shared definitions for the mmio_bank register bank:
//     - request size encodings (SZ_BYTE / SZ_WORD)
//     - bus FSM state encoding
//     - word-offset helpers for the registers that follow the OUTk block
// ----------------------------------------------------------------------------
package mmio_pkg;

    localparam logic SZ_BYTE = 1'b0;
    localparam logic SZ_WORD = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    // The OUTk registers occupy offsets 0..num_out-1; the rest follow them.
    function automatic int unsigned OFF_IN(input int unsigned num_out);
        return num_out;
    endfunction

    function automatic int unsigned OFF_STATUS(input int unsigned num_out);
        return num_out + 1;
    endfunction

    function automatic int unsigned OFF_ENABLE(input int unsigned num_out);
        return num_out + 2;
    endfunction

endpackage

// File: rtl/mmio_sync.sv
// ----------------------------------------------------------------------------
// mmio_sync
//   IN_W-bit multi-flop synchroniser for asynchronous input pins.
//   Optional macro: MMIO_BANK_IRQ_EN adds the rising-edge pulse output.
// Ports
//   Clk      in   clock
//   Reset_n  in   asynchronous active-low reset
//   pins_in  in   raw asynchronous pins
//   sync_out out  synchronised pins (last stage)
//   rise     out  (MMIO_BANK_IRQ_EN only) high in the cycle whose closing edge
//                 makes a synchronised bit go 0->1
// ----------------------------------------------------------------------------
module mmio_sync #(
    parameter int IN_W   = 7,
    parameter int STAGES = 2
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic [IN_W-1:0] pins_in,
    output logic [IN_W-1:0] sync_out
`ifdef MMIO_BANK_IRQ_EN
    ,
    output logic [IN_W-1:0] rise
`endif
);

    logic [IN_W-1:0] stage_reg [STAGES];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= pins_in;
            for (int i = 1; i < STAGES; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign sync_out = stage_reg[STAGES-1];

`ifdef MMIO_BANK_IRQ_EN
    // Looking one stage ahead lets the flag register update on the same edge
    // that the synchronised value changes.
    assign rise = stage_reg[STAGES-2] & ~stage_reg[STAGES-1];
`endif

endmodule

// File: rtl/mmio_bank.sv
// ----------------------------------------------------------------------------
// mmio_bank
//   Memory-mapped IO register bank on a valid/ready request bus with a
//   one-cycle response pulse. Word offsets from BASE_ADDR:
//     0..NUM_OUT-1  OUTk    RW, drive out_regs
//     NUM_OUT       IN      RO, synchronised pins_in (zero-extended)
//     NUM_OUT+1     STATUS  W1C edge flags    (MMIO_BANK_IRQ_EN only)
//     NUM_OUT+2     ENABLE  RW interrupt mask (MMIO_BANK_IRQ_EN only)
//   Optional macro: MMIO_BANK_IRQ_EN (edge-capture interrupt).
// Ports
//   Clk, Reset_n           clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready only while idle)
//   req_we, req_size       1=write / 0=read, 0=byte / 1=word
//   req_addr, req_wdata    byte address, write data (bytes use [7:0])
//   resp_valid             one-cycle response pulse
//   resp_rdata, resp_err   read data and error flag, valid with resp_valid
//   out_regs               OUTk on [32k+31:32k]
//   pins_in                asynchronous input pins
//   irq                    level interrupt (0 when the feature is absent)
// ----------------------------------------------------------------------------
module mmio_bank
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h2000,
    parameter int          NUM_OUT     = 4,
    parameter int          IN_W        = 7,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic                   req_size,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   resp_valid,
    output logic [31:0]            resp_rdata,
    output logic                   resp_err,
    output logic [NUM_OUT*32-1:0]  out_regs,
    input  logic [IN_W-1:0]        pins_in,
    output logic                   irq
);

`ifdef MMIO_BANK_IRQ_EN
    localparam int unsigned NUM_OFFS = OFF_ENABLE(NUM_OUT) + 1;
`else
    localparam int unsigned NUM_OFFS = OFF_IN(NUM_OUT) + 1;
`endif

    state_t          state_reg;
    logic            ready_reg;
    logic            resp_valid_reg;
    logic [31:0]     resp_rdata_reg;
    logic            resp_err_reg;

    logic [31:0]     rel_addr;
    logic [31:0]     word_off;
    logic [1:0]      lane;
    logic            in_window;
    logic            misaligned;
    logic            acc_err;
    logic            accept;
    logic            do_write;
    logic [31:0]     wmask;
    logic [31:0]     wval;
    logic [31:0]     rd_word;
    logic [31:0]     rdata_next;
    logic [IN_W-1:0] pins_sync;

    // ---------------- decode ----------------
    assign rel_addr   = req_addr - BASE_ADDR;
    assign word_off   = rel_addr >> 2;
    assign lane       = req_addr[1:0];
    assign in_window  = (req_addr >= BASE_ADDR) && (word_off < NUM_OFFS);
    assign misaligned = (req_size == SZ_WORD) && (lane != 2'd0);
    assign acc_err    = !in_window || misaligned ||
                        (req_we && (word_off == OFF_IN(NUM_OUT)));
    assign accept     = (state_reg == ST_IDLE) && req_valid;
    assign do_write   = accept && req_we && !acc_err;

    // Byte writes replicate the byte so the mask alone selects the lane.
    always_comb begin
        if (req_size == SZ_BYTE) begin
            wmask = 32'h0000_00FF << {lane, 3'b000};
            wval  = {4{req_wdata[7:0]}};
        end else begin
            wmask = '1;
            wval  = req_wdata;
        end
    end

    // ---------------- OUTk registers ----------------
    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
            logic [31:0] val_reg;
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    val_reg <= '0;
                end else if (do_write && (word_off == 32'(gi))) begin
                    val_reg <= (val_reg & ~wmask) | (wval & wmask);
                end
            end
            assign out_regs[32*gi +: 32] = val_reg;
        end
    endgenerate

    // ---------------- input pins / interrupt ----------------
`ifdef MMIO_BANK_IRQ_EN
    logic [IN_W-1:0] pins_rise;
    logic [IN_W-1:0] status_reg;
    logic [IN_W-1:0] enable_reg;
    logic [IN_W-1:0] status_clr;
    logic            irq_reg;

    mmio_sync #(
        .IN_W   (IN_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .pins_in  (pins_in),
        .sync_out (pins_sync),
        .rise     (pins_rise)
    );

    assign status_clr = (do_write && (word_off == OFF_STATUS(NUM_OUT))) ?
                        (wval[IN_W-1:0] & wmask[IN_W-1:0]) : '0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            status_reg <= '0;
            enable_reg <= '0;
            irq_reg    <= 1'b0;
        end else begin
            // OR-ing the new edges after the clear makes a coincident edge win.
            status_reg <= (status_reg & ~status_clr) | pins_rise;
            if (do_write && (word_off == OFF_ENABLE(NUM_OUT))) begin
                enable_reg <= (enable_reg & ~wmask[IN_W-1:0]) |
                              (wval[IN_W-1:0] & wmask[IN_W-1:0]);
            end
            irq_reg <= |(status_reg & enable_reg);
        end
    end

    assign irq = irq_reg;
`else
    mmio_sync #(
        .IN_W   (IN_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .pins_in  (pins_in),
        .sync_out (pins_sync)
    );

    assign irq = 1'b0;
`endif

    // ---------------- read mux ----------------
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (word_off == 32'(k)) begin
                rd_word = out_regs[32*k +: 32];
            end
        end
        if (word_off == OFF_IN(NUM_OUT)) begin
            rd_word[IN_W-1:0] = pins_sync;
        end
`ifdef MMIO_BANK_IRQ_EN
        if (word_off == OFF_STATUS(NUM_OUT)) begin
            rd_word[IN_W-1:0] = status_reg;
        end
        if (word_off == OFF_ENABLE(NUM_OUT)) begin
            rd_word[IN_W-1:0] = enable_reg;
        end
`endif
    end

    always_comb begin
        if (acc_err || req_we) begin
            rdata_next = '0;
        end else if (req_size == SZ_BYTE) begin
            rdata_next = {24'h0, rd_word[{lane, 3'b000} +: 8]};
        end else begin
            rdata_next = rd_word;
        end
    end

    // ---------------- bus FSM ----------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg      <= ST_IDLE;
            ready_reg      <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        state_reg      <= ST_RESP;
                        ready_reg      <= 1'b0;
                        resp_valid_reg <= 1'b1;
                        resp_rdata_reg <= rdata_next;
                        resp_err_reg   <= acc_err;
                    end
                end
                ST_RESP: begin
                    state_reg      <= ST_IDLE;
                    ready_reg      <= 1'b1;
                    resp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_mmio_bank.sv
// ----------------------------------------------------------------------------
// tb_mmio_bank
//   Self-checking bench for mmio_bank: a transaction-level model of the
//   register map is compared against the DUT on every falling clock edge,
//   with directed literal checks and a randomised access phase.
//   Honours MMIO_BANK_IRQ_EN when compiled with it.
// ----------------------------------------------------------------------------
module tb_mmio_bank;

    localparam logic [31:0] BASE    = 32'h2000;
    localparam int          NUM_OUT = 4;
    localparam int          IN_W    = 7;
    localparam int          SYNC    = 2;
`ifdef MMIO_BANK_IRQ_EN
    localparam int          NREGS   = NUM_OUT + 3;
`else
    localparam int          NREGS   = NUM_OUT + 1;
`endif
    localparam logic [31:0] A_IN     = BASE + 32'(4 * NUM_OUT);
    localparam logic [31:0] A_STATUS = BASE + 32'(4 * (NUM_OUT + 1));
    localparam logic [31:0] A_ENABLE = BASE + 32'(4 * (NUM_OUT + 2));

    logic                  Clk = 1'b0;
    logic                  Reset_n = 1'b0;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic                  req_we = 1'b0;
    logic                  req_size = 1'b0;
    logic [31:0]           req_addr = '0;
    logic [31:0]           req_wdata = '0;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic [NUM_OUT*32-1:0] out_regs;
    logic [IN_W-1:0]       pins_in = '0;
    logic                  irq;

    int checks = 0;
    int errors = 0;

    mmio_bank #(
        .BASE_ADDR   (BASE),
        .NUM_OUT     (NUM_OUT),
        .IN_W        (IN_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .out_regs   (out_regs),
        .pins_in    (pins_in),
        .irq        (irq)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0]     m_out [NUM_OUT];
    logic [IN_W-1:0] m_status = '0;
    logic [IN_W-1:0] m_enable = '0;
    logic [IN_W-1:0] pin_hist [$];
    bit              m_busy = 1'b0;
    bit              exp_resp_valid = 1'b0;
    bit              exp_err = 1'b0;
    bit              exp_is_read = 1'b0;
    logic [31:0]     exp_rdata = '0;
    bit              exp_irq = 1'b0;

    // Pins as seen by the bank: the value presented SYNC edges ago.
    function automatic logic [IN_W-1:0] synced_pins();
        if (pin_hist.size() >= SYNC) return pin_hist[pin_hist.size() - SYNC];
        return '0;
    endfunction

    logic [IN_W-1:0] t_old_sync, t_new_sync, t_clr;
    logic [31:0]     t_val, t_wr;
    int              t_off, t_lane;
    bit              t_err;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < NUM_OUT; k++) m_out[k] = '0;
            m_status = '0;
            m_enable = '0;
            pin_hist.delete();
            m_busy = 1'b0;
            exp_resp_valid = 1'b0;
            exp_irq = 1'b0;
        end else begin
            t_old_sync = synced_pins();
            pin_hist.push_back(pins_in);
            if (pin_hist.size() > SYNC + 1) void'(pin_hist.pop_front());
            t_new_sync = synced_pins();
            t_clr = '0;
            exp_irq = |(m_status & m_enable);
            if (m_busy) begin
                m_busy = 1'b0;
                exp_resp_valid = 1'b0;
            end else if (req_valid) begin
                m_busy = 1'b1;
                exp_resp_valid = 1'b1;
                exp_is_read = !req_we;
                t_lane = int'(req_addr % 4);
                t_off  = (req_addr >= BASE) ? int'((req_addr - BASE) / 4) : -1;
                t_err  = (req_addr < BASE) || ((req_addr - BASE) >= 32'(4 * NREGS)) ||
                         (req_size && t_lane != 0) || (req_we && t_off == NUM_OUT);
                t_val = '0;
                if (!t_err) begin
                    if (t_off < NUM_OUT)          t_val = m_out[t_off];
                    else if (t_off == NUM_OUT)     t_val = 32'(t_old_sync);
                    else if (t_off == NUM_OUT + 1) t_val = 32'(m_status);
                    else                           t_val = 32'(m_enable);
                end
                // t_val now holds the addressed register's current content.
                t_wr = t_val;
                if (req_size) t_wr = req_wdata;
                else          t_wr[8*t_lane +: 8] = req_wdata[7:0];
                if (!req_size) t_val = 32'(t_val[8*t_lane +: 8]);
                exp_err = t_err;
                exp_rdata = t_err ? 32'h0 : t_val;
                if (req_we && !t_err) begin
                    if (t_off < NUM_OUT) begin
                        m_out[t_off] = t_wr;
                    end else if (t_off == NUM_OUT + 1) begin
                        t_clr = req_size ? req_wdata[IN_W-1:0] : '0;
                        if (!req_size) begin
                            t_wr = '0;
                            t_wr[8*t_lane +: 8] = req_wdata[7:0];
                            t_clr = t_wr[IN_W-1:0];
                        end
                    end else begin
                        m_enable = t_wr[IN_W-1:0];
                    end
                end
            end
`ifdef MMIO_BANK_IRQ_EN
            m_status = (m_status & ~t_clr) | (t_new_sync & ~t_old_sync);
`endif
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge Clk) begin
        chk("req_ready", 32'(req_ready), 32'(!m_busy));
        chk("resp_valid", 32'(resp_valid), 32'(exp_resp_valid));
        if (exp_resp_valid) begin
            chk("resp_err", 32'(resp_err), 32'(exp_err));
            if (exp_is_read || exp_err) chk("resp_rdata", resp_rdata, exp_rdata);
        end
        chk("irq", 32'(irq), 32'(exp_irq));
        for (int k = 0; k < NUM_OUT; k++)
            chk($sformatf("out_reg%0d", k), out_regs[32*k +: 32], m_out[k]);
    end

    // ---------------- driver ----------------
    task automatic access(input logic we, input logic sz, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int n;
        n = 0;
        rd = '0;
        er = 1'b1;
        while (!req_ready && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge Clk);
        n = 0;
        while (!resp_valid && n < 4) begin
            @(negedge Clk);
            n++;
        end
        chk("resp_timeout", 32'(resp_valid), 32'd1);
        rd = resp_rdata;
        er = resp_err;
        req_valid = 1'b0;
        $display("txn we=%0d size=%0d addr=%h wdata=%h -> rdata=%h err=%0d",
                 we, sz, addr, wd, rd, er);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;
    logic        er;

    initial begin
        repeat (3) @(negedge Clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_out_regs", 32'(|out_regs), 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);

        // 1: word write / read
        access(1, 1, BASE, 32'hDEADBEEF, rd, er);
        chk("t1_wr_err", 32'(er), 32'd0);
        access(0, 1, BASE, 32'h0, rd, er);
        chk("t1_rd_data", rd, 32'hDEADBEEF);
        chk("t1_rd_err", 32'(er), 32'd0);
        chk("t1_out0", out_regs[31:0], 32'hDEADBEEF);

        // 2: byte lane write / reads
        access(1, 0, BASE + 32'h6, 32'h0000005A, rd, er);
        access(0, 1, BASE + 32'h4, 32'h0, rd, er);
        chk("t2_word_rd", rd, 32'h005A0000);
        access(0, 0, BASE + 32'h6, 32'h0, rd, er);
        chk("t2_byte_rd", rd, 32'h0000005A);

        // 3: misaligned and out-of-map
        access(0, 1, BASE + 32'h2, 32'h0, rd, er);
        chk("t3_misalign_err", 32'(er), 32'd1);
        chk("t3_misalign_data", rd, 32'h0);
        access(1, 1, BASE + 32'(4 * (NUM_OUT + 3)), 32'hFFFFFFFF, rd, er);
        chk("t3_oor_err", 32'(er), 32'd1);
        chk("t3_oor_out0", out_regs[31:0], 32'hDEADBEEF);
        chk("t3_oor_out1", out_regs[63:32], 32'h005A0000);

        // 4: input synchroniser latency and read-only IN
        pins_in = 7'h55;
        repeat (SYNC - 1) @(negedge Clk);
        access(0, 1, A_IN, 32'h0, rd, er);
        chk("t4_in_early", rd, 32'h0);
        access(0, 1, A_IN, 32'h0, rd, er);
        chk("t4_in_synced", rd, 32'h00000055);
        access(1, 1, A_IN, 32'h12345678, rd, er);
        chk("t4_in_write_err", 32'(er), 32'd1);

`ifdef MMIO_BANK_IRQ_EN
        // 5: edge capture interrupt
        pins_in = '0;
        repeat (SYNC + 2) @(negedge Clk);
        access(1, 1, A_STATUS, 32'h7F, rd, er);
        access(1, 1, A_ENABLE, 32'h1, rd, er);
        repeat (2) @(negedge Clk);
        chk("t5_irq_idle", 32'(irq), 32'd0);
        pins_in = 7'h01;
        repeat (SYNC + 2) @(negedge Clk);
        chk("t5_irq_set", 32'(irq), 32'd1);
        access(0, 1, A_STATUS, 32'h0, rd, er);
        chk("t5_status", rd, 32'h1);
        access(1, 1, A_STATUS, 32'h0, rd, er);
        access(0, 1, A_STATUS, 32'h0, rd, er);
        chk("t5_w0_keeps", rd, 32'h1);
        access(1, 1, A_STATUS, 32'h1, rd, er);
        repeat (2) @(negedge Clk);
        chk("t5_irq_clr", 32'(irq), 32'd0);
        pins_in = '0;
        repeat (SYNC + 2) @(negedge Clk);
        pins_in = 7'h01;
        repeat (SYNC - 1) @(negedge Clk);
        access(1, 1, A_STATUS, 32'h1, rd, er);
        access(0, 1, A_STATUS, 32'h0, rd, er);
        chk("t5_set_wins", rd, 32'h1);
`else
        access(0, 1, A_STATUS, 32'h0, rd, er);
        chk("t5_status_absent_err", 32'(er), 32'd1);
        access(1, 1, A_ENABLE, 32'h1, rd, er);
        chk("t5_enable_absent_err", 32'(er), 32'd1);
        chk("t5_irq_tied", 32'(irq), 32'd0);
`endif

        // randomised accesses
        for (int t = 0; t < 250; t++) begin
            logic [31:0] a;
            if ($urandom_range(0, 3) == 0) pins_in = IN_W'($urandom);
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = BASE - 32'(4 * $urandom_range(1, 4));
                default: a = BASE + 32'($urandom_range(0, 4 * NREGS + 7));
            endcase
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, rd, er);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge Clk);
        end

        // 6: reset in the middle of an access
        while (!req_ready) @(negedge Clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 1'b1;
        req_addr  = BASE + 32'h4;
        req_wdata = 32'hA5A50001;
        @(posedge Clk);
        #1;
        Reset_n   = 1'b0;
        req_valid = 1'b0;
        @(negedge Clk);
        chk("t6_resp_dropped", 32'(resp_valid), 32'd0);
        chk("t6_out_cleared", 32'(|out_regs), 32'd0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("t6_ready_after", 32'(req_ready), 32'd1);
        repeat (2) @(negedge Clk);
        chk("t6_no_pulse", 32'(resp_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
